vec_issue_ctrl: RTL and testbench
=================================

// Module: vec_issue_ctrl
// PURPOSE
//  Sequencer between scalar-core vector dispatch and the vector datapath. Accepts one decoded
//  vector instruction at a time and holds the scalar core off while the instruction is active.
//  Config instructions: pulses the CSR write. Arith/load/store: expands the instruction into
//  one micro-op per register of the LMUL group, with valid/ready handshake to execute/LSU.
// PARAMETERS
//  VREG_AW   5   vector register address width (32 architectural vregs)
//  LMUL_W    3   width of vtype.vlmul field
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  inst_valid   in   1        decoder has a vector instruction (is_vec) for issue
//  inst_type    in   2        00 arith, 01 load, 10 store, 11 config
//  vd_addr      in   VREG_AW  destination vreg (vs3 for stores)
//  vs1_addr     in   VREG_AW  source 1 vreg base
//  vs2_addr     in   VREG_AW  source 2 vreg base
//  vlmul        in   LMUL_W   current vtype.vlmul, sampled on accept
//  inst_ready   out  1        controller can accept; scalar pipeline stalls while low
//  csr_we       out  1        1-cycle pulse: commit scalar1/scalar2 to vl/vtype CSRs
//  uop_valid    out  1        micro-op valid to datapath/LSU
//  uop_ready    in   1        datapath/LSU accepts micro-op
//  uop_type     out  2        inst_type of the active instruction
//  uop_vd       out  VREG_AW  vd_base + idx
//  uop_vs1      out  VREG_AW  vs1_base + idx (arith only, else 0)
//  uop_vs2      out  VREG_AW  vs2_base + idx
//  uop_last     out  1        current micro-op is the last of the group
//  mem_done     in   1        LSU reports all memory traffic of the instruction complete
//  busy         out  1        state != IDLE
//  illegal      out  1        1-cycle pulse: reserved vlmul or misaligned register group
// BEHAVIOUR
//  - Reset: state IDLE, idx=0; inst_ready=1, all other outputs 0. Reset in any state aborts
//    the instruction; an in-flight micro-op is dropped with no completion.
//  - States: IDLE, CHECK, CONFIG, ISSUE, WAIT_MEM.
//  - IDLE: inst_ready=1. On inst_valid: latch type/vd/vs1/vs2/vlmul, idx<=0, go to CHECK.
//    inst_ready=0 in every other state.
//  - CHECK (1 cycle): config -> CONFIG. Else nreg = 1<<vlmul for vlmul 0..3 (1,2,4,8).
//    vlmul 4 is reserved -> illegal. vlmul 5..7 per CONFIGURATION. Any of vd/vs2 (and vs1
//    for arith) not a multiple of nreg -> illegal. On illegal: illegal=1 for one cycle,
//    then IDLE; no micro-op issued. Otherwise -> ISSUE.
//  - CONFIG (1 cycle): csr_we=1, then IDLE. Accept-to-csr_we latency is 2 cycles.
//  - ISSUE: uop_valid=1. Address outputs = base + idx, 5-bit add. Alignment guarantees
//    no wrap past v31. uop_last = (idx == nreg-1). Outputs hold stable while uop_ready=0.
//    On uop_valid && uop_ready: idx++. On the handshake of the last micro-op: arith -> IDLE;
//    load/store -> WAIT_MEM. First micro-op is valid 2 cycles after accept.
//  - WAIT_MEM: uop_valid=0 and busy=1 until mem_done=1, then IDLE.
//    If mem_done is already asserted in the cycle of the last handshake, go directly to IDLE.
//    mem_done is ignored in all other states.
//  - Back-to-back: a new instruction is accepted in the first IDLE cycle after completion.
// CONFIGURATION
//  VEC_ISSUE_FRAC_LMUL_EN defined: vlmul 5,6,7 (LMUL 1/8,1/4,1/2) are legal with nreg=1.
//  Undefined: vlmul 5..7 are treated as reserved and raise illegal the same way as vlmul 4.
// TESTING
//  - Config inst after reset: inst_valid=1,type=11 at cycle 0 -> csr_we=1 only at cycle 2,
//    inst_ready=0 in cycles 1..2, back to 1 at cycle 3.
//  - Arith vlmul=2, vd=8, vs1=16, vs2=4, uop_ready=1 -> 4 consecutive uops (vd 8..11,
//    vs1 16..19, vs2 4..7); uop_last only on the 4th; IDLE on the next cycle.
//  - Backpressure: same inst with uop_ready toggling 0/1 -> each uop held stable until
//    accepted; exactly 4 handshakes; no skipped or repeated index.
//  - Load vlmul=1, vd=2: 2 uops, then WAIT_MEM; mem_done after 5 cycles -> IDLE next
//    cycle; mem_done while in ISSUE has no effect.
//  - Illegal: vlmul=3, vd=4 -> illegal pulse, no uop_valid. vlmul=6 -> illegal without
//    VEC_ISSUE_FRAC_LMUL_EN; a single uop when the macro is defined.
//  - Reset asserted during ISSUE on the 3rd of 8 uops -> next cycle: IDLE, uop_valid=0,
//    inst_ready=1; a following inst restarts at idx 0.

Source files
------------

// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue sequencer: one instruction at a time, expanded into LMUL-group micro-ops.
// Optional feature macro: VEC_ISSUE_FRAC_LMUL_EN (fractional LMUL 1/8..1/2 legal as a single register).
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a new instruction
// CHECK    | one cycle: classify config vs. grouped, validate vlmul/alignment
// CONFIG   | one cycle: csr_we pulse
// ISSUE    | emit micro-ops idx 0..nreg-1 under valid/ready
// WAIT_MEM | load/store issued, waiting for LSU completion
module vec_issue_ctrl #(
  parameter int VREG_AW = 5,
  parameter int LMUL_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_valid,
  input  logic [1:0]         inst_type,
  input  logic [VREG_AW-1:0] vd_addr,
  input  logic [VREG_AW-1:0] vs1_addr,
  input  logic [VREG_AW-1:0] vs2_addr,
  input  logic [LMUL_W-1:0]  vlmul,
  output logic               inst_ready,
  output logic               csr_we,
  output logic               uop_valid,
  input  logic               uop_ready,
  output logic [1:0]         uop_type,
  output logic [VREG_AW-1:0] uop_vd,
  output logic [VREG_AW-1:0] uop_vs1,
  output logic [VREG_AW-1:0] uop_vs2,
  output logic               uop_last,
  input  logic               mem_done,
  output logic               busy,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_CONFIG,
    S_ISSUE,
    S_WAIT_MEM
  } state_e;

  localparam logic [1:0] TYPE_ARITH  = 2'b00;
  localparam logic [1:0] TYPE_CONFIG = 2'b11;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [1:0]         type_q;
  logic [VREG_AW-1:0] vd_q, vs1_q, vs2_q;
  logic [LMUL_W-1:0]  vlmul_q;

  logic [2:0]         grp_mask;
  logic               lmul_legal;
  logic [VREG_AW-1:0] grp_mask_w;
  logic               misaligned;
  logic               is_arith;
  logic               last_uop;

  // grp_mask = nreg - 1; a base register is aligned when its low bits under the mask are zero
  always_comb begin
    grp_mask   = 3'd0;
    lmul_legal = 1'b0;
    case (vlmul_q)
      LMUL_W'(0): begin grp_mask = 3'd0; lmul_legal = 1'b1; end
      LMUL_W'(1): begin grp_mask = 3'd1; lmul_legal = 1'b1; end
      LMUL_W'(2): begin grp_mask = 3'd3; lmul_legal = 1'b1; end
      LMUL_W'(3): begin grp_mask = 3'd7; lmul_legal = 1'b1; end
`ifdef VEC_ISSUE_FRAC_LMUL_EN
      LMUL_W'(5), LMUL_W'(6), LMUL_W'(7): begin grp_mask = 3'd0; lmul_legal = 1'b1; end
`endif
      default: begin grp_mask = 3'd0; lmul_legal = 1'b0; end
    endcase
  end

  assign is_arith   = (type_q == TYPE_ARITH);
  assign grp_mask_w = VREG_AW'(grp_mask);
  assign misaligned = ((vd_q & grp_mask_w) != '0) ||
                      ((vs2_q & grp_mask_w) != '0) ||
                      (is_arith && ((vs1_q & grp_mask_w) != '0));
  assign last_uop   = (idx_q == grp_mask);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inst_ready = 1'b0;
    csr_we     = 1'b0;
    uop_valid  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          state_d = S_CHECK;
          idx_d   = 3'd0;
        end
      end
      S_CHECK: begin
        if (type_q == TYPE_CONFIG) begin
          state_d = S_CONFIG;
        end else if (!lmul_legal || misaligned) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_CONFIG: begin
        csr_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_ISSUE: begin
        uop_valid = 1'b1;
        if (uop_ready) begin
          idx_d = idx_q + 3'd1;
          if (last_uop) begin
            // a completion already signalled on the final handshake skips WAIT_MEM
            if (is_arith || mem_done) state_d = S_IDLE;
            else                      state_d = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      type_q  <= 2'b00;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vlmul_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == S_IDLE && inst_valid) begin
        type_q  <= inst_type;
        vd_q    <= vd_addr;
        vs1_q   <= vs1_addr;
        vs2_q   <= vs2_addr;
        vlmul_q <= vlmul;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign uop_type = type_q;
  assign uop_last = (state_q == S_ISSUE) && last_uop;
  assign uop_vd   = (state_q == S_ISSUE) ? vd_q + VREG_AW'(idx_q) : '0;
  assign uop_vs1  = (state_q == S_ISSUE && is_arith) ? vs1_q + VREG_AW'(idx_q) : '0;
  assign uop_vs2  = (state_q == S_ISSUE) ? vs2_q + VREG_AW'(idx_q) : '0;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl; expected values are hand-derived per scenario.
// Honours VEC_ISSUE_FRAC_LMUL_EN for the fractional-LMUL case.
module tb_vec_issue_ctrl;

  logic       clk;
  logic       reset;
  logic       inst_valid;
  logic [1:0] inst_type;
  logic [4:0] vd_addr, vs1_addr, vs2_addr;
  logic [2:0] vlmul;
  logic       inst_ready, csr_we, uop_valid, uop_ready, uop_last, mem_done, busy, illegal;
  logic [1:0] uop_type;
  logic [4:0] uop_vd, uop_vs1, uop_vs2;

  int n_cmp = 0;
  int n_err = 0;

  vec_issue_ctrl #(.VREG_AW(5), .LMUL_W(3)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_type(inst_type),
    .vd_addr(vd_addr), .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vlmul(vlmul),
    .inst_ready(inst_ready), .csr_we(csr_we),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_type(uop_type),
    .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_last(uop_last),
    .mem_done(mem_done), .busy(busy), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in the current IDLE cycle and advances to the CHECK cycle.
  task automatic send(input logic [1:0] t, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] lm);
    inst_valid = 1'b1; inst_type = t;
    vd_addr = d; vs1_addr = s1; vs2_addr = s2; vlmul = lm;
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    n_cmp++;
    if (inst_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", inst_ready);
    end
    n_cmp++;
    if ({csr_we, uop_valid, busy, illegal, uop_last, uop_type, uop_vd, uop_vs1, uop_vs2} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got csr_we=%b uop_valid=%b busy=%b illegal=%b last=%b type=%0d vd=%0d vs1=%0d vs2=%0d want all 0",
               csr_we, uop_valid, busy, illegal, uop_last, uop_type, uop_vd, uop_vs1, uop_vs2);
    end
  endtask

  task automatic test_config();
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'd0);
    n_cmp++;
    if ({inst_ready, csr_we, busy} !== 3'b001) begin
      n_err++; $display("FAIL config_c1: got ready=%b csr_we=%b busy=%b want 0 0 1", inst_ready, csr_we, busy);
    end
    tick();
    n_cmp++;
    if ({inst_ready, csr_we, uop_valid} !== 3'b010) begin
      n_err++; $display("FAIL config_c2: got ready=%b csr_we=%b uop_valid=%b want 0 1 0", inst_ready, csr_we, uop_valid);
    end
    tick();
    n_cmp++;
    if ({inst_ready, csr_we, busy} !== 3'b100) begin
      n_err++; $display("FAIL config_c3: got ready=%b csr_we=%b busy=%b want 1 0 0", inst_ready, csr_we, busy);
    end
  endtask

  task automatic test_arith();
    logic [4:0] e_vd, e_vs1, e_vs2;
    uop_ready = 1'b1;
    send(2'b00, 5'd8, 5'd16, 5'd4, 3'd2);
    n_cmp++;
    if (uop_valid !== 1'b0) begin
      n_err++; $display("FAIL arith_check_cycle: got uop_valid=%b want 0", uop_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      e_vd = 5'(8 + i); e_vs1 = 5'(16 + i); e_vs2 = 5'(4 + i);
      n_cmp++;
      if ({uop_valid, uop_type, uop_vd, uop_vs1, uop_vs2, uop_last} !==
          {1'b1, 2'b00, e_vd, e_vs1, e_vs2, (i == 3)}) begin
        n_err++;
        $display("FAIL arith_uop[%0d]: got v=%b t=%0d vd=%0d vs1=%0d vs2=%0d last=%b want v=1 t=0 vd=%0d vs1=%0d vs2=%0d last=%b",
                 i, uop_valid, uop_type, uop_vd, uop_vs1, uop_vs2, uop_last, e_vd, e_vs1, e_vs2, (i == 3));
      end
      tick();
    end
    n_cmp++;
    if ({busy, uop_valid, inst_ready} !== 3'b001) begin
      n_err++; $display("FAIL arith_done: got busy=%b uop_valid=%b ready=%b want 0 0 1", busy, uop_valid, inst_ready);
    end
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int hs = 0;
    int cyc = 0;
    logic [4:0] e_vd, e_vs1, e_vs2;
    uop_ready = 1'b0;
    send(2'b00, 5'd8, 5'd16, 5'd4, 3'd2);
    tick();
    while (exp_idx < 4 && cyc < 40) begin
      e_vd = 5'(8 + exp_idx); e_vs1 = 5'(16 + exp_idx); e_vs2 = 5'(4 + exp_idx);
      n_cmp++;
      if ({uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last} !== {1'b1, e_vd, e_vs1, e_vs2, (exp_idx == 3)}) begin
        n_err++;
        $display("FAIL bp_uop cyc%0d: got v=%b vd=%0d vs1=%0d vs2=%0d last=%b want v=1 vd=%0d vs1=%0d vs2=%0d last=%b",
                 cyc, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last, e_vd, e_vs1, e_vs2, (exp_idx == 3));
      end
      uop_ready = cyc[0];
      tick();
      if (uop_ready) begin
        exp_idx++;
        hs++;
      end
      cyc++;
    end
    uop_ready = 1'b1;
    n_cmp++;
    if (hs !== 4 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_done: got handshakes=%0d busy=%b want 4 0", hs, busy);
    end
  endtask

  task automatic test_back_to_back();
    send(2'b00, 5'd0, 5'd2, 5'd4, 3'd1);
    tick();
    tick();
    tick();
    n_cmp++;
    if (inst_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: got ready=%b want 1", inst_ready);
    end
    send(2'b11, 5'd0, 5'd0, 5'd0, 3'd0);
    n_cmp++;
    if ({busy, inst_ready} !== 2'b10) begin
      n_err++; $display("FAIL b2b_accept: got busy=%b ready=%b want 1 0", busy, inst_ready);
    end
    tick();
    tick();
  endtask

  task automatic test_load();
    uop_ready = 1'b1;
    send(2'b01, 5'd2, 5'd3, 5'd6, 3'd1);
    tick();
    mem_done = 1'b1;
    n_cmp++;
    if ({uop_valid, uop_type, uop_vd, uop_vs1, uop_vs2, uop_last} !== {1'b1, 2'b01, 5'd2, 5'd0, 5'd6, 1'b0}) begin
      n_err++;
      $display("FAIL load_uop0: got v=%b t=%0d vd=%0d vs1=%0d vs2=%0d last=%b want 1 1 2 0 6 0",
               uop_valid, uop_type, uop_vd, uop_vs1, uop_vs2, uop_last);
    end
    tick();
    mem_done = 1'b0;
    n_cmp++;
    if ({uop_valid, uop_vd, uop_vs2, uop_last} !== {1'b1, 5'd3, 5'd7, 1'b1}) begin
      n_err++;
      $display("FAIL load_uop1: got v=%b vd=%0d vs2=%0d last=%b want 1 3 7 1", uop_valid, uop_vd, uop_vs2, uop_last);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({uop_valid, busy, inst_ready} !== 3'b010) begin
        n_err++; $display("FAIL load_wait[%0d]: got v=%b busy=%b ready=%b want 0 1 0", i, uop_valid, busy, inst_ready);
      end
      tick();
    end
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    n_cmp++;
    if ({busy, inst_ready} !== 2'b01) begin
      n_err++; $display("FAIL load_done: got busy=%b ready=%b want 0 1", busy, inst_ready);
    end
    // single-uop store with completion already signalled on the handshake
    send(2'b10, 5'd5, 5'd0, 5'd9, 3'd0);
    tick();
    mem_done = 1'b1;
    n_cmp++;
    if ({uop_valid, uop_type, uop_vd, uop_vs2, uop_last} !== {1'b1, 2'b10, 5'd5, 5'd9, 1'b1}) begin
      n_err++; $display("FAIL store_uop: got v=%b t=%0d vd=%0d vs2=%0d last=%b want 1 2 5 9 1",
                        uop_valid, uop_type, uop_vd, uop_vs2, uop_last);
    end
    tick();
    mem_done = 1'b0;
    n_cmp++;
    if ({busy, inst_ready} !== 2'b01) begin
      n_err++; $display("FAIL store_direct_idle: got busy=%b ready=%b want 0 1", busy, inst_ready);
    end
  endtask

  task automatic test_illegal();
    uop_ready = 1'b1;
    send(2'b00, 5'd4, 5'd0, 5'd8, 3'd3);
    n_cmp++;
    if ({illegal, uop_valid} !== 2'b10) begin
      n_err++; $display("FAIL illegal_align: got illegal=%b v=%b want 1 0", illegal, uop_valid);
    end
    tick();
    n_cmp++;
    if ({illegal, uop_valid, busy, inst_ready} !== 4'b0001) begin
      n_err++; $display("FAIL illegal_after: got illegal=%b v=%b busy=%b ready=%b want 0 0 0 1",
                        illegal, uop_valid, busy, inst_ready);
    end
    send(2'b01, 5'd0, 5'd0, 5'd0, 3'd4);
    n_cmp++;
    if (illegal !== 1'b1) begin
      n_err++; $display("FAIL illegal_vlmul4: got illegal=%b want 1", illegal);
    end
    tick();
    send(2'b00, 5'd2, 5'd1, 5'd4, 3'd1);
    n_cmp++;
    if (illegal !== 1'b1) begin
      n_err++; $display("FAIL illegal_vs1: got illegal=%b want 1", illegal);
    end
    tick();
    send(2'b00, 5'd3, 5'd5, 5'd7, 3'd6);
`ifdef VEC_ISSUE_FRAC_LMUL_EN
    n_cmp++;
    if (illegal !== 1'b0) begin
      n_err++; $display("FAIL frac_legal: got illegal=%b want 0", illegal);
    end
    tick();
    n_cmp++;
    if ({uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last} !== {1'b1, 5'd3, 5'd5, 5'd7, 1'b1}) begin
      n_err++; $display("FAIL frac_uop: got v=%b vd=%0d vs1=%0d vs2=%0d last=%b want 1 3 5 7 1",
                        uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last);
    end
    tick();
`else
    n_cmp++;
    if ({illegal, uop_valid} !== 2'b10) begin
      n_err++; $display("FAIL frac_reserved: got illegal=%b v=%b want 1 0", illegal, uop_valid);
    end
    tick();
`endif
    n_cmp++;
    if ({busy, uop_valid} !== 2'b00) begin
      n_err++; $display("FAIL frac_end: got busy=%b v=%b want 0 0", busy, uop_valid);
    end
  endtask

  task automatic test_reset_mid();
    uop_ready = 1'b1;
    send(2'b00, 5'd8, 5'd16, 5'd24, 3'd3);
    tick();
    tick();
    tick();
    n_cmp++;
    if ({uop_valid, uop_vd, uop_vs1, uop_vs2} !== {1'b1, 5'd10, 5'd18, 5'd26}) begin
      n_err++; $display("FAIL mid_third_uop: got v=%b vd=%0d vs1=%0d vs2=%0d want 1 10 18 26",
                        uop_valid, uop_vd, uop_vs1, uop_vs2);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({busy, uop_valid, inst_ready} !== 3'b001) begin
      n_err++; $display("FAIL mid_reset: got busy=%b v=%b ready=%b want 0 0 1", busy, uop_valid, inst_ready);
    end
    send(2'b00, 5'd0, 5'd2, 5'd4, 3'd1);
    tick();
    n_cmp++;
    if ({uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last} !== {1'b1, 5'd0, 5'd2, 5'd4, 1'b0}) begin
      n_err++; $display("FAIL mid_restart: got v=%b vd=%0d vs1=%0d vs2=%0d last=%b want 1 0 2 4 0",
                        uop_valid, uop_vd, uop_vs1, uop_vs2, uop_last);
    end
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst_type = 2'b00;
    vd_addr = '0; vs1_addr = '0; vs2_addr = '0; vlmul = '0;
    uop_ready = 1'b0; mem_done = 1'b0;
    test_reset();
    test_config();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_load();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
